// File: rtl/lsu_store_buffer_if.sv
// Pipeline-side request/response bundle of the LSU store buffer.
// The master side is the pipeline and the slave side is the buffer.
interface lsu_store_buffer_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [10:0] req_adrs;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_adrs, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_adrs, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/lsu_store_buffer.sv
// Circular store buffer between the LSU pipeline and data memory.
// Loads are forwarded from pending stores, and responses have a fixed one-cycle latency.
module lsu_store_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   lsu_store_buffer_if.slave        bus,
   input  logic                     wr_hold,
   output logic                     sb_empty,
   output logic                     mem_w_en,
   output logic [10:0]              mem_w_adrs,
   output logic [31:0]              mem_data_in,
   output logic                     mem_r_en1,
   output logic [10:0]              mem_r_adrs1,
   input  logic [31:0]              mem_data_out1
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [10:0]     adrs_q [DEPTH];
   logic [31:0]     data_q [DEPTH];
   logic [PtrW-1:0] head_q, tail_q;
   logic [CntW-1:0] count_q;
   logic            rsp_valid_q;
   logic            fwd_hit_q;
   logic [31:0]     fwd_data_q;

   logic            full;
   logic            store_acc;
   logic            load_acc;
   logic            drain;
   logic            hit;
   logic [31:0]     hit_data;

   assign full      = (count_q == CntW'(DEPTH));
   assign sb_empty  = (count_q == '0);
   assign store_acc = bus.req_valid & ~full & bus.req_we;
   assign load_acc  = bus.req_valid & ~full & ~bus.req_we;
   assign drain     = ~sb_empty & ~wr_hold;

   assign bus.req_ready = ~full;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = fwd_hit_q ? fwd_data_q : mem_data_out1;

   assign mem_w_en    = drain;
   assign mem_w_adrs  = adrs_q[head_q];
   assign mem_data_in = data_q[head_q];
   assign mem_r_en1   = load_acc & ~hit;
   assign mem_r_adrs1 = bus.req_adrs;

   // Scan oldest to youngest so the last match wins; the head entry counts even while draining.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if ((CntW'(i) < count_q) && (adrs_q[head_q + PtrW'(i)] == bus.req_adrs)) begin
            hit      = 1'b1;
            hit_data = data_q[head_q + PtrW'(i)];
         end
      end
   end

   // Entry storage is never cleared; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (store_acc) begin
         adrs_q[tail_q] <= bus.req_adrs;
         data_q[tail_q] <= bus.req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         rsp_valid_q <= 1'b0;
         fwd_hit_q   <= 1'b0;
         fwd_data_q  <= '0;
      end else begin
         if (store_acc) begin
            tail_q <= tail_q + PtrW'(1);
         end
         if (drain) begin
            head_q <= head_q + PtrW'(1);
         end
         case ({store_acc, drain})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
         rsp_valid_q <= load_acc;
         fwd_hit_q   <= load_acc & hit;
         fwd_data_q  <= hit_data;
      end
   end
endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed bench for lsu_store_buffer: it covers draining, forwarding, back-pressure and mid-run reset,
// with a small data memory model.
module tb_lsu_store_buffer;
   logic        clk = 1'b0;
   logic        reset;
   logic        wr_hold;
   logic        sb_empty;
   logic        mem_w_en;
   logic [10:0] mem_w_adrs;
   logic [31:0] mem_data_in;
   logic        mem_r_en1;
   logic [10:0] mem_r_adrs1;
   logic [31:0] mem_data_out1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lsu_store_buffer_if bus();

   lsu_store_buffer #(.DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .wr_hold       (wr_hold),
      .sb_empty      (sb_empty),
      .mem_w_en      (mem_w_en),
      .mem_w_adrs    (mem_w_adrs),
      .mem_data_in   (mem_data_in),
      .mem_r_en1     (mem_r_en1),
      .mem_r_adrs1   (mem_r_adrs1),
      .mem_data_out1 (mem_data_out1)
   );

   // Data memory model with a bench-side preload port and a log of every write.
   logic [31:0] mem [2048];
   logic        pre_we = 1'b0;
   logic [10:0] pre_adrs = '0;
   logic [31:0] pre_data = '0;
   logic [10:0] wlog_a [$];
   logic [31:0] wlog_d [$];

   always @(posedge clk) begin
      if (pre_we) mem[pre_adrs] <= pre_data;
      if (mem_w_en) begin
         mem[mem_w_adrs] <= mem_data_in;
         wlog_a.push_back(mem_w_adrs);
         wlog_d.push_back(mem_data_in);
      end
      if (mem_r_en1) mem_data_out1 <= mem[mem_r_adrs1];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [10:0] a, input logic [31:0] d);
      bus.req_valid = v;
      bus.req_we    = we;
      bus.req_adrs  = a;
      bus.req_wdata = d;
   endtask

   task automatic preload(input logic [10:0] a, input logic [31:0] d);
      step();
      pre_we = 1'b1; pre_adrs = a; pre_data = d;
      step();
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; wr_hold = 1'b0;
      drive(1'b0, 1'b0, 11'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
      checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL reset_sb_empty got=%b exp=1", sb_empty); end
      checks++; if (mem_w_en !== 1'b0) begin failures++; $display("FAIL reset_mem_w_en got=%b exp=0", mem_w_en); end
      checks++; if (mem_r_en1 !== 1'b0) begin failures++; $display("FAIL reset_mem_r_en1 got=%b exp=0", mem_r_en1); end
      checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
   endtask

   task automatic test_single_store();
      step(); drive(1'b1, 1'b1, 11'h005, 32'h0000_00AA);
      @(negedge clk);
      checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", bus.req_ready); end
      checks++; if (mem_w_en !== 1'b0) begin failures++; $display("FAIL single_no_early_write got=%b exp=0", mem_w_en); end
      step(); drive(1'b0, 1'b0, 11'h0, 32'h0);
      @(negedge clk);
      checks++; if (mem_w_en !== 1'b1) begin failures++; $display("FAIL single_w_en got=%b exp=1", mem_w_en); end
      checks++; if (mem_w_adrs !== 11'h005) begin failures++; $display("FAIL single_w_adrs got=%h exp=005", mem_w_adrs); end
      checks++; if (mem_data_in !== 32'h0000_00AA) begin failures++; $display("FAIL single_w_data got=%h exp=000000aa", mem_data_in); end
      checks++; if (sb_empty !== 1'b0) begin failures++; $display("FAIL single_not_empty got=%b exp=0", sb_empty); end
      step(); @(negedge clk);
      checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL single_empty_after got=%b exp=1", sb_empty); end
      checks++; if (mem_w_en !== 1'b0) begin failures++; $display("FAIL single_w_en_after got=%b exp=0", mem_w_en); end
   endtask

   task automatic test_fill_drain();
      int base;
      base = wlog_a.size();
      wr_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(); drive(1'b1, 1'b1, 11'h010 + 11'(i), 32'h100 + 32'(i));
         @(negedge clk);
         checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, bus.req_ready); end
      end
      // A store offered while full must be ignored.
      step(); drive(1'b1, 1'b1, 11'h1FF, 32'hDEAD_BEEF);
      @(negedge clk);
      checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", bus.req_ready); end
      checks++; if (mem_w_en !== 1'b0) begin failures++; $display("FAIL full_held got=%b exp=0", mem_w_en); end
      step(); drive(1'b0, 1'b0, 11'h0, 32'h0); wr_hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (mem_w_en !== 1'b1) begin failures++; $display("FAIL drain_w_en[%0d] got=%b exp=1", i, mem_w_en); end
         checks++; if (mem_w_adrs !== 11'h010 + 11'(i)) begin failures++; $display("FAIL drain_adrs[%0d] got=%h exp=%h", i, mem_w_adrs, 11'h010 + 11'(i)); end
         checks++; if (mem_data_in !== 32'h100 + 32'(i)) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, mem_data_in, 32'h100 + 32'(i)); end
         checks++; if (bus.req_ready !== (i != 0)) begin failures++; $display("FAIL drain_ready[%0d] got=%b exp=%b", i, bus.req_ready, (i != 0)); end
         step();
      end
      @(negedge clk);
      checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", sb_empty); end
      checks++; if (wlog_a.size() - base !== 4) begin failures++; $display("FAIL drain_write_count got=%0d exp=4", wlog_a.size() - base); end
   endtask

   task automatic test_forward();
      int n;
      wr_hold = 1'b1;
      step(); drive(1'b1, 1'b1, 11'h020, 32'h0000_1111);
      step(); drive(1'b1, 1'b1, 11'h020, 32'h0000_2222);
      step(); drive(1'b1, 1'b0, 11'h020, 32'h0);
      @(negedge clk);
      checks++; if (mem_r_en1 !== 1'b0) begin failures++; $display("FAIL fwd_r_en got=%b exp=0", mem_r_en1); end
      step(); drive(1'b0, 1'b0, 11'h0, 32'h0);
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL fwd_rsp_valid got=%b exp=1", bus.rsp_valid); end
      checks++; if (bus.rsp_rdata !== 32'h0000_2222) begin failures++; $display("FAIL fwd_youngest got=%h exp=00002222", bus.rsp_rdata); end
      step(); wr_hold = 1'b0;
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL fwd_single_pulse got=%b exp=0", bus.rsp_valid); end
      n = 0;
      while (sb_empty !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL fwd_drain_timeout got=%b exp=1", sb_empty); end
   endtask

   task automatic test_load_miss();
      preload(11'h030, 32'h0000_0BAD);
      step(); drive(1'b1, 1'b0, 11'h030, 32'h0);
      @(negedge clk);
      checks++; if (mem_r_en1 !== 1'b1) begin failures++; $display("FAIL miss_r_en got=%b exp=1", mem_r_en1); end
      checks++; if (mem_r_adrs1 !== 11'h030) begin failures++; $display("FAIL miss_r_adrs got=%h exp=030", mem_r_adrs1); end
      step(); drive(1'b0, 1'b0, 11'h0, 32'h0);
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL miss_rsp_valid got=%b exp=1", bus.rsp_valid); end
      checks++; if (bus.rsp_rdata !== 32'h0000_0BAD) begin failures++; $display("FAIL miss_rdata got=%h exp=00000bad", bus.rsp_rdata); end
   endtask

   task automatic test_drain_forward();
      preload(11'h040, 32'hDEAD_0040);
      step(); drive(1'b1, 1'b1, 11'h040, 32'h4444_4040);
      step(); drive(1'b1, 1'b0, 11'h040, 32'h0);
      @(negedge clk);
      checks++; if (mem_w_en !== 1'b1) begin failures++; $display("FAIL dfwd_draining got=%b exp=1", mem_w_en); end
      checks++; if (mem_r_en1 !== 1'b0) begin failures++; $display("FAIL dfwd_r_en got=%b exp=0", mem_r_en1); end
      step(); drive(1'b0, 1'b0, 11'h0, 32'h0);
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL dfwd_rsp_valid got=%b exp=1", bus.rsp_valid); end
      checks++; if (bus.rsp_rdata !== 32'h4444_4040) begin failures++; $display("FAIL dfwd_rdata got=%h exp=44444040", bus.rsp_rdata); end
      checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL dfwd_empty got=%b exp=1", sb_empty); end
   endtask

   task automatic test_back_to_back();
      logic        we_t [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [10:0] ad_t [5] = '{11'h050, 11'h050, 11'h050, 11'h050, 11'h030};
      logic [31:0] d_t  [5] = '{32'h5000, 32'h0, 32'h5001, 32'h0, 32'h0};
      logic [31:0] ex_t [5] = '{32'h0, 32'h5000, 32'h0, 32'h5001, 32'h0BAD};
      logic        exp_v;
      for (int k = 0; k < 5; k++) begin
         step(); drive(1'b1, we_t[k], ad_t[k], d_t[k]);
         @(negedge clk);
         exp_v = (k > 0) && !we_t[(k > 0) ? k - 1 : 0];
         checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", k, bus.req_ready); end
         checks++; if (bus.rsp_valid !== exp_v) begin failures++; $display("FAIL b2b_rsp_valid[%0d] got=%b exp=%b", k, bus.rsp_valid, exp_v); end
         if (exp_v) begin
            checks++; if (bus.rsp_rdata !== ex_t[k - 1]) begin failures++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", k, bus.rsp_rdata, ex_t[k - 1]); end
         end
      end
      step(); drive(1'b0, 1'b0, 11'h0, 32'h0);
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_last_valid got=%b exp=1", bus.rsp_valid); end
      checks++; if (bus.rsp_rdata !== ex_t[4]) begin failures++; $display("FAIL b2b_last_rdata got=%h exp=%h", bus.rsp_rdata, ex_t[4]); end
   endtask

   task automatic test_reset_midop();
      int base;
      base = wlog_a.size();
      wr_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); drive(1'b1, 1'b1, 11'h060 + 11'(i), 32'h600 + 32'(i));
      end
      step(); drive(1'b1, 1'b0, 11'h070, 32'h0); reset = 1'b1;
      @(negedge clk);
      checks++; if (sb_empty !== 1'b0) begin failures++; $display("FAIL rmid_pending got=%b exp=0", sb_empty); end
      step(); drive(1'b0, 1'b0, 11'h0, 32'h0);
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_rsp_valid got=%b exp=0", bus.rsp_valid); end
      checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL rmid_empty got=%b exp=1", sb_empty); end
      checks++; if (mem_w_en !== 1'b0) begin failures++; $display("FAIL rmid_w_en got=%b exp=0", mem_w_en); end
      checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", bus.req_ready); end
      step(); reset = 1'b0; wr_hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (mem_w_en !== 1'b0) begin failures++; $display("FAIL rmid_no_write[%0d] got=%b exp=0", i, mem_w_en); end
         step();
      end
      checks++; if (wlog_a.size() !== base) begin failures++; $display("FAIL rmid_write_count got=%0d exp=%0d", wlog_a.size(), base); end
   endtask

   initial begin
      reset = 1'b1;
      wr_hold = 1'b0;
      drive(1'b0, 1'b0, 11'h0, 32'h0);
      test_reset();
      test_single_store();
      test_fill_drain();
      test_forward();
      test_load_miss();
      test_drain_forward();
      test_back_to_back();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/lsu_store_buffer.md
LSU_STORE_BUFFER -- requirements
Module: lsu_store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, store-buffer entry count (power of two, 2..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  pipeline memory request present.
REQ-005 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_adrs  input  11  word address.
REQ-008 req_wdata  input  32  store data.
REQ-009 rsp_valid  output  1  load data valid, one cycle pulse per load.
REQ-010 rsp_rdata  output  32  load data.
REQ-011 wr_hold  input  1  blocks draining to memory while high.
REQ-012 sb_empty  output  1  buffer holds no pending stores (fence indicator).
REQ-013 mem_w_en / mem_w_adrs / mem_data_in  output  1/11/32  data-memory write port.
REQ-014 mem_r_en1 / mem_r_adrs1  output  1/11  data-memory read port 1.
REQ-015 mem_data_out1  input  32  read data, valid the cycle after mem_r_en1.

Function
REQ-016 Buffer SHALL be a circular FIFO of DEPTH {adrs, data} entries with head/tail pointers and a count of width clog2(DEPTH)+1; pointers wrap from DEPTH-1 to 0.
REQ-017 req_ready SHALL equal !full (count==DEPTH), independent of req_valid and req_we; no same-cycle drain lookahead.
REQ-018 Accepted store (req_valid & req_ready & req_we) SHALL be written at tail, tail and count advancing at the clock edge.
REQ-019 Accepted load SHALL compare req_adrs against all valid entries, including the entry draining this cycle; on hit, the youngest matching entry's data is selected.
REQ-020 Load hit SHALL hold mem_r_en1 low and register the forwarded data; load miss SHALL drive mem_r_en1=1, mem_r_adrs1=req_adrs combinationally in the accept cycle.
REQ-021 rsp_valid SHALL pulse high exactly one cycle after every accepted load (fixed latency 1); rsp_rdata = forwarded data if hit, else mem_data_out1; rsp_rdata is don't-care when rsp_valid=0.
REQ-022 Drain: mem_w_en = !sb_empty & !wr_hold; mem_w_adrs/mem_data_in = head entry; head advances and count decrements on each cycle mem_w_en=1.
REQ-023 Simultaneous enqueue and drain SHALL leave count unchanged and move both pointers.
REQ-024 Stores SHALL reach memory in acceptance order; no coalescing, no dropping.
REQ-025 A load SHALL never return a value older than any store accepted before it.
REQ-026 sb_empty = (count==0), combinational from registered state.
REQ-027 No throughput loss: back-to-back loads/stores accepted every cycle while not full.

Reset
REQ-028 While reset is high on a clock edge: count, head, tail = 0; rsp_valid = 0; pending forward flag = 0; buffer contents discarded.
REQ-029 Outputs after reset: req_ready=1, sb_empty=1, mem_w_en=0, mem_r_en1=0, rsp_valid=0.
REQ-030 Reset asserted mid-operation SHALL cancel any in-flight load response and discard undrained stores; combinational outputs are evaluated from reset state in the following cycle.
REQ-031 Buffer data RAM need not be cleared; only pointers/flags are reset.

Verification
REQ-032 Store 0x0000_00AA to 0x005, wr_hold=0 -> next cycle mem_w_en=1, mem_w_adrs=0x005, mem_data_in=0x0000_00AA; sb_empty returns to 1 after that cycle.
REQ-033 wr_hold=1, stores to 0x010..0x013 -> req_ready=0 after 4th accept; release hold -> four writes in order, one per cycle, req_ready=1 after first drain.
REQ-034 wr_hold=1, store 0x1111 then 0x2222 to 0x020, load 0x020 -> mem_r_en1=0, next cycle rsp_valid=1, rsp_rdata=0x2222.
REQ-035 Memory preloaded 0x0BAD at 0x030, empty buffer, load 0x030 -> mem_r_en1=1 in accept cycle, rsp_valid=1, rsp_rdata=0x0BAD one cycle later.
REQ-036 Store to 0x040 draining in same cycle as load 0x040 accepted -> load forwarded, rsp_rdata equals stored data.
REQ-037 Reset asserted with 3 pending stores and a load in flight -> next cycle rsp_valid=0, sb_empty=1, mem_w_en=0, no further memory writes.
